// File: rtl/rp_adder_pkg.sv
// rp_adder_pkg: rp_inc command encodings shared by the control unit and the RP update unit.
package rp_adder_pkg;
    localparam logic [1:0] RP_HOLD = 2'b00;
    localparam logic [1:0] RP_INC  = 2'b01;
    localparam logic [1:0] RP_DEC  = 2'b10;
    localparam logic [1:0] RP_RSVD = 2'b11;
endpackage

// File: rtl/rp_reg.sv
// rp_reg: WIDTH-bit register with load enable and async active-low reset to RESET_VALUE.
module rp_reg #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= RESET_VALUE;
        else if (en) q <= d;
endmodule

// File: rtl/rp_adder.sv
// rp_adder: return-stack pointer register stepped +1/-1/hold per cycle by rp_inc.
module rp_adder
    import rp_adder_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [1:0]       rp_inc,
    output logic [WIDTH-1:0] rp
);
    logic             en;
    logic [WIDTH-1:0] nxt;
    // Hold and the reserved code both leave the register disabled; wrap is natural modulo arithmetic.
    always_comb begin
        en  = (rp_inc == RP_INC) || (rp_inc == RP_DEC);
        nxt = (rp_inc == RP_INC) ? rp + WIDTH'(1) : rp - WIDTH'(1);
    end
    rp_reg #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_reg (
        .clk(CLK), .rst_n(reset), .en(en), .d(nxt), .q(rp)
    );
endmodule

// File: tb/tb_rp_adder.sv
// tb_rp_adder: directed table, async reset sequences and a randomized walk against an arithmetic model.
module tb_rp_adder;
    import rp_adder_pkg::*;
    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  rp_inc = RP_INC;
    logic [15:0] rp;
    int checks = 0;
    int failures = 0;
    always #5 CLK = ~CLK;
    rp_adder #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
        .CLK(CLK), .reset(reset), .rp_inc(rp_inc), .rp(rp)
    );
    typedef struct {
        logic [1:0]  cmd;
        int          n;
        logic [15:0] exp;
    } vec_t;
    vec_t vt[8];
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask
    task automatic step(input logic [1:0] c, input int n);
        rp_inc = c;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask
    initial begin
        logic [15:0] model;
        logic [1:0]  c;
        vt = '{'{RP_INC, 3, 16'd3}, '{RP_HOLD, 1, 16'd3}, '{RP_DEC, 1, 16'd2},
               '{RP_INC, 1, 16'd3}, '{RP_HOLD, 2, 16'd3}, '{RP_DEC, 3, 16'd0},
               '{RP_DEC, 1, 16'hFFFF}, '{RP_INC, 1, 16'h0000}};
        #1;
        check("reset_immediate", rp, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            rp_inc = 2'($urandom_range(0, 3));
            @(posedge CLK);
            #1;
            check("reset_held", rp, 16'h0000);
        end
        reset = 1'b1;
        step(RP_HOLD, 1);
        check("reset_release_hold", rp, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            step(vt[i].cmd, vt[i].n);
            check($sformatf("table_%0d", i), rp, vt[i].exp);
        end
        step(RP_INC, 5);
        check("to_five", rp, 16'd5);
        step(RP_RSVD, 4);
        check("reserved_hold", rp, 16'd5);
        step(RP_INC, 2);
        check("to_seven", rp, 16'd7);
        rp_inc = RP_INC;
        #2 reset = 1'b0;
        #1 check("async_mid_count", rp, 16'h0000);
        #1 reset = 1'b1;
        @(posedge CLK);
        #1;
        check("after_async_release", rp, 16'd1);
        model = 16'd1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                reset = 1'b0;
                #1;
                model = 16'h0000;
                check("rand_async_reset", rp, model);
                reset = 1'b1;
            end
            c = 2'($urandom_range(0, 3));
            step(c, 1);
            if (c == 2'd1) model = model + 16'd1;
            else if (c == 2'd2) model = model - 16'd1;
            check($sformatf("rand_%0d_cmd%0d", i, c), rp, model);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
